// File: rtl/scaler_input_ctrl.sv
// scaler_input_ctrl: crops the incoming video stream to a programmable window
// and writes each in-window line into the line-buffer RAM FIFO.
module scaler_input_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     HSIn,
    input  logic                     VSIn,
    input  logic                     dInEn,
    input  logic [DATA_WIDTH-1:0]    dIn,
    input  logic [ADDRESS_WIDTH-1:0] xBgn,
    input  logic [ADDRESS_WIDTH-1:0] xEnd,
    input  logic [ADDRESS_WIDTH-1:0] yBgn,
    input  logic [ADDRESS_WIDTH-1:0] yEnd,
    input  logic                     fifoFull,
    output logic                     ramWrEn,
    output logic [ADDRESS_WIDTH-1:0] ramAddrIn,
    output logic [DATA_WIDTH-1:0]    ramWrData,
    output logic                     lineDone,
    output logic                     frameDone,
    output logic                     overflow
);

    localparam int unsigned AW = ADDRESS_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_SKIP      = 2'd3
    } state_e;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
        sat_inc = (v == {AW{1'b1}}) ? v : v + AW'(1);
    endfunction

    state_e          state_q, state_d;

    // Sync sampling: s1 is the registered sync, s2 its previous value.
    logic            hs_s1_q, hs_s1_d, hs_s2_q, hs_s2_d;
    logic            vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d;
    // Edge detection is armed only once s2 holds a post-reset sample, so a
    // sync already high at reset release does not look like an edge.
    logic            arm1_q, arm1_d, arm2_q, arm2_d;

    logic [AW-1:0]   col_q, col_d;
    logic [AW-1:0]   row_q, row_d;
    logic            first_row_q, first_row_d;
    logic            frame_end_q, frame_end_d;

    logic [AW-1:0]   x_bgn_q, x_bgn_d;
    logic [AW-1:0]   x_end_q, x_end_d;
    logic [AW-1:0]   y_bgn_q, y_bgn_d;
    logic [AW-1:0]   y_end_q, y_end_d;

    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            line_done_q, line_done_d;
    logic            frame_done_q, frame_done_d;
    logic            overflow_q, overflow_d;

    logic            hs_rise;
    logic            vs_rise;
    logic [AW-1:0]   cur_x;
    logic [AW-1:0]   cur_row;

    // Next-state, counters, window latch and write generation.
    always_comb begin
        state_d      = state_q;
        hs_s1_d      = HSIn;
        hs_s2_d      = hs_s1_q;
        vs_s1_d      = VSIn;
        vs_s2_d      = vs_s1_q;
        arm1_d       = 1'b1;
        arm2_d       = arm1_q;
        col_d        = col_q;
        row_d        = row_q;
        first_row_d  = first_row_q;
        frame_end_d  = frame_end_q;
        x_bgn_d      = x_bgn_q;
        x_end_d      = x_end_q;
        y_bgn_d      = y_bgn_q;
        y_end_d      = y_end_q;
        wr_en_d      = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        hs_rise      = hs_s1_q & ~hs_s2_q & arm2_q;
        vs_rise      = vs_s1_q & ~vs_s2_q & arm2_q;
        cur_x        = col_q;
        cur_row      = row_q;

        // Frame start wins over everything and drops any line in progress.
        if (vs_rise) begin
            x_bgn_d     = xBgn;
            x_end_d     = xEnd;
            y_bgn_d     = yBgn;
            y_end_d     = yEnd;
            overflow_d  = 1'b0;
            first_row_d = 1'b1;
            frame_end_d = 1'b0;
            state_d     = ST_WAIT_LINE;
        end

        // Line start: restart the column and decide whether to capture the line.
        if (hs_rise) begin
            cur_x = '0;
            if (vs_rise || (state_q != ST_IDLE)) begin
                cur_row     = first_row_d ? '0 : sat_inc(row_q);
                row_d       = cur_row;
                first_row_d = 1'b0;
                if ((cur_row < y_bgn_d) || (cur_row > y_end_d) ||
                    (x_end_d < x_bgn_d) || frame_end_d) begin
                    state_d = ST_SKIP;
                end else if (fifoFull) begin
                    overflow_d = 1'b1;
                    state_d    = ST_SKIP;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
        end

        col_d = dInEn ? sat_inc(cur_x) : cur_x;

        // In-window pixel write; the last column closes the line.
        if ((state_d == ST_ACTIVE) && dInEn &&
            (cur_x >= x_bgn_d) && (cur_x <= x_end_d)) begin
            wr_en_d = 1'b1;
            addr_d  = cur_x - x_bgn_d;
            data_d  = dIn;
            if (cur_x == x_end_d) begin
                line_done_d = 1'b1;
                state_d     = ST_SKIP;
                if (row_d == y_end_d) begin
                    frame_done_d = 1'b1;
                    frame_end_d  = 1'b1;
                end
            end
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hs_s1_q      <= 1'b0;
            hs_s2_q      <= 1'b0;
            vs_s1_q      <= 1'b0;
            vs_s2_q      <= 1'b0;
            arm1_q       <= 1'b0;
            arm2_q       <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            first_row_q  <= 1'b0;
            frame_end_q  <= 1'b0;
            x_bgn_q      <= '0;
            x_end_q      <= '0;
            y_bgn_q      <= '0;
            y_end_q      <= '0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hs_s1_q      <= hs_s1_d;
            hs_s2_q      <= hs_s2_d;
            vs_s1_q      <= vs_s1_d;
            vs_s2_q      <= vs_s2_d;
            arm1_q       <= arm1_d;
            arm2_q       <= arm2_d;
            col_q        <= col_d;
            row_q        <= row_d;
            first_row_q  <= first_row_d;
            frame_end_q  <= frame_end_d;
            x_bgn_q      <= x_bgn_d;
            x_end_q      <= x_end_d;
            y_bgn_q      <= y_bgn_d;
            y_end_q      <= y_end_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ramWrEn   = wr_en_q;
    assign ramAddrIn = addr_q;
    assign ramWrData = data_q;
    assign lineDone  = line_done_q;
    assign frameDone = frame_done_q;
    assign overflow  = overflow_q;

endmodule
